// File: rtl/paridade_serial.sv
// ---------------------------------------------------------------------------
// paridade_serial
//   Bit-serial even/odd parity generator/checker. It takes a frame of WIDTH
//   data bits, LSB first, followed by one received parity bit. It computes the
//   parity of the data, compares it with the received bit, and keeps a
//   saturating count of frames that failed the check.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clear       synchronous frame abort; wins over a same-cycle bit_valid
//   odd_mode    0 = even, 1 = odd parity; sampled with data bit 0
//   bit_valid   bit_in is valid this cycle
//   bit_in      serial data bit, or the parity bit at the end of a frame
//   busy        a frame is in progress (registered)
//   frame_done  one-cycle pulse; data_out/parity_out/parity_err are updated
//   data_out    assembled data word, held until the next frame_done
//   parity_out  XOR(data) ^ latched odd_mode
//   parity_err  received parity differs from parity_out
//   err_count   number of frames with parity_err, saturating at all-ones
// ---------------------------------------------------------------------------
module paridade_serial #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             odd_mode,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             frame_done,
    output logic [WIDTH-1:0] data_out,
    output logic             parity_out,
    output logic             parity_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               acc_q,    acc_d;
    logic               odd_q,    odd_d;
    logic [WIDTH-1:0]   shreg_q,  shreg_d;
    logic [WIDTH-1:0]   dout_q,   dout_d;
    logic               pout_q,   pout_d;
    logic               perr_q,   perr_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;
    logic [ERR_W-1:0]   errc_q,   errc_d;
    logic               par_calc;

    assign par_calc = acc_q ^ odd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        odd_d   = odd_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        pout_d  = pout_q;
        perr_d  = perr_q;
        errc_d  = errc_q;
        done_d  = 1'b0;

        if (clear) begin
            // Abort: drop the partial frame (and any same-cycle bit),
            // keep the last completed frame's results.
            state_d = S_DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
        end else if (bit_valid) begin
            unique case (state_q)
                S_DATA: begin
                    shreg_d[cnt_q] = bit_in;
                    acc_d          = acc_q ^ bit_in;
                    if (cnt_q == '0)
                        odd_d = odd_mode;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // cnt wraps to 0 here; busy stays high via S_PAR
                        state_d = S_PAR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_PAR: begin
                    dout_d  = shreg_q;
                    pout_d  = par_calc;
                    perr_d  = bit_in ^ par_calc;
                    done_d  = 1'b1;
                    if ((bit_in ^ par_calc) && (errc_q != {ERR_W{1'b1}}))
                        errc_d = errc_q + ERR_W'(1);
                    state_d = S_DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
                default: state_d = S_DATA;
            endcase
        end

        busy_d = (cnt_d != '0) || (state_d == S_PAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            odd_q   <= 1'b0;
            shreg_q <= '0;
            dout_q  <= '0;
            pout_q  <= 1'b0;
            perr_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            odd_q   <= odd_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            pout_q  <= pout_d;
            perr_q  <= perr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            errc_q  <= errc_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign data_out   = dout_q;
    assign parity_out = pout_q;
    assign parity_err = perr_q;
    assign err_count  = errc_q;

endmodule

// File: tb/tb_paridade_serial.sv
module tb_paridade_serial;

    logic clk = 1'b0;
    logic rst_n, clear, odd_mode, bit_valid, bit_in;

    logic       busy, f_done, p_out, p_err;
    logic [7:0] d_out, e_cnt8;
    logic       busy2, f_done2, p_out2, p_err2;
    logic [7:0] d_out2;
    logic [1:0] e_cnt2;

    always #5 clk = ~clk;

    paridade_serial #(.WIDTH(8), .ERR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .odd_mode(odd_mode),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy),
        .frame_done(f_done), .data_out(d_out), .parity_out(p_out),
        .parity_err(p_err), .err_count(e_cnt8));

    paridade_serial #(.WIDTH(8), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .odd_mode(odd_mode),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy2),
        .frame_done(f_done2), .data_out(d_out2), .parity_out(p_out2),
        .parity_err(p_err2), .err_count(e_cnt2));

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       e;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_c8   = 0;   // reference error counts (plain integers, clamped)
    int   m_c2   = 0;
    logic [7:0] last_d = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every frame_done pops one expected frame.
    always @(negedge clk) begin
        if (rst_n && (f_done || f_done2)) begin
            chk("done_agree", {31'd0, f_done}, {31'd0, f_done2});
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out",    {24'd0, d_out},  {24'd0, e.d});
                chk("parity_out",  {31'd0, p_out},  {31'd0, e.p});
                chk("parity_err",  {31'd0, p_err},  {31'd0, e.e});
                chk("err_count8",  {24'd0, e_cnt8}, {24'd0, e.c8});
                chk("data_out2",   {24'd0, d_out2}, {24'd0, e.d});
                chk("parity_out2", {31'd0, p_out2}, {31'd0, e.p});
                chk("parity_err2", {31'd0, p_err2}, {31'd0, e.e});
                chk("err_count2",  {30'd0, e_cnt2}, {30'd0, e.c2});
            end
        end
    end

    task automatic drive_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
    endtask

    task automatic gap(input int gmax);
        repeat ($urandom_range(gmax, 0)) begin
            odd_mode = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic odd, input logic par, input int gmax);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        e.d = d;
        e.p = logic'((ones + int'(odd)) % 2);   // makes ones+parity even/odd
        e.e = (par != e.p);
        if (e.e) begin
            m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
            m_c2 = (m_c2 < 3)   ? m_c2 + 1 : 3;
        end
        e.c8 = 8'(m_c8);
        e.c2 = 2'(m_c2);
        q.push_back(e);
        last_d = d;
        for (int i = 0; i < 8; i++) begin
            odd_mode = (i == 0) ? odd : 1'($urandom);   // later changes must be ignored
            drive_bit(d[i]);
            if (i == 0) chk("busy_in_frame", {31'd0, busy}, 32'd1);
            gap(gmax);
        end
        odd_mode = 1'($urandom);
        drive_bit(par);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_c8  = 0;
        m_c2  = 0;
        last_d = 8'h00;
        #2;
        chk("rst_data_out", {24'd0, d_out}, 32'd0);
        chk("rst_flags", {26'd0, busy, f_done, p_out, p_err, busy2, f_done2}, 32'd0);
        chk("rst_err_count", {22'd0, e_cnt2, e_cnt8}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int wait_cnt;
        rst_n = 1'b0; clear = 1'b0; odd_mode = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // 1: even A5, correct parity
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        // 2: odd 01, both received parity values
        send_frame(8'h01, 1'b1, 1'b1, 0);
        send_frame(8'h01, 1'b1, 1'b0, 0);
        // 3: even FF with gaps, parity 1
        send_frame(8'hFF, 1'b0, 1'b1, 3);
        repeat (2) @(posedge clk);
        #1;

        // 4: abort after 5 bits, clear with bit 6
        for (int i = 0; i < 5; i++) drive_bit(1'($urandom));
        clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; bit_valid = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_no_done", {31'd0, f_done}, 32'd0);
        chk("clear_data_kept", {24'd0, d_out}, {24'd0, last_d});
        send_frame(8'h3C, 1'b0, 1'b0, 1);

        // 5: five wrong-parity frames from a fresh reset (2-bit counter saturates)
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send_frame(d, 1'b0, ~(^d), 0);
        end

        // 6: back-to-back frames, then a partial frame killed by reset
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        send_frame(8'hC3, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        do_reset();
        send_frame(8'h81, 1'b0, 1'b0, 0);

        // Random frames
        for (int k = 0; k < 40; k++)
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(2, 0)));

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 50) begin
            @(posedge clk);
            wait_cnt++;
        end
        #1;
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
